// File: rtl/raster_block_gen.sv
// Splits a tile into BSxBS blocks in raster order, dropping blocks outside the bbox or fully outside an edge.
// One SCAN cycle per block; accepted blocks are held on the output until ready_out (at most one per 2 cycles).
`timescale 1ns/1ps
`ifndef VX_RASTER_DIM_BITS
`define VX_RASTER_DIM_BITS 16
`endif
`ifndef VX_RASTER_PID_BITS
`define VX_RASTER_PID_BITS 16
`endif
`ifndef RASTER_DATA_BITS
`define RASTER_DATA_BITS 32
`endif

module raster_block_gen #(
  parameter int TILE_LOGSIZE  = 6,
  parameter int BLOCK_LOGSIZE = 5
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic                                            valid_in,
  output logic                                            ready_in,
  input  logic [`VX_RASTER_DIM_BITS-1:0]                  xloc_in,
  input  logic [`VX_RASTER_DIM_BITS-1:0]                  yloc_in,
  input  logic [`VX_RASTER_DIM_BITS-1:0]                  xmin_in,
  input  logic [`VX_RASTER_DIM_BITS-1:0]                  xmax_in,
  input  logic [`VX_RASTER_DIM_BITS-1:0]                  ymin_in,
  input  logic [`VX_RASTER_DIM_BITS-1:0]                  ymax_in,
  input  logic [`VX_RASTER_PID_BITS-1:0]                  pid_in,
  input  logic [2:0][2:0][`RASTER_DATA_BITS-1:0]          edges_in,
  output logic                                            valid_out,
  output logic [`VX_RASTER_DIM_BITS-1:0]                  xloc_out,
  output logic [`VX_RASTER_DIM_BITS-1:0]                  yloc_out,
  output logic [`VX_RASTER_DIM_BITS-1:0]                  xmin_out,
  output logic [`VX_RASTER_DIM_BITS-1:0]                  xmax_out,
  output logic [`VX_RASTER_DIM_BITS-1:0]                  ymin_out,
  output logic [`VX_RASTER_DIM_BITS-1:0]                  ymax_out,
  output logic [`VX_RASTER_PID_BITS-1:0]                  pid_out,
  output logic [2:0][2:0][`RASTER_DATA_BITS-1:0]          edges_out,
  input  logic                                            ready_out,
  output logic                                            busy_out
);

  localparam int DIM  = `VX_RASTER_DIM_BITS;
  localparam int DIM1 = DIM + 1;
  localparam int PID  = `VX_RASTER_PID_BITS;
  localparam int DW   = `RASTER_DATA_BITS;
  localparam int LD   = TILE_LOGSIZE - BLOCK_LOGSIZE;
  localparam int BS   = 1 << BLOCK_LOGSIZE;
  localparam int NBLK = 1 << (2 * LD);
  localparam int IW   = (LD > 0) ? 2 * LD : 1;
  localparam int CW   = (LD > 0) ? LD : 1;
  // Wide enough that c + 2*max(a,0)*(BS-1) can never overflow.
  localparam int EW   = DW + BLOCK_LOGSIZE + 2;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           bidx_q, bidx_d;
  logic [DIM-1:0]          xloc_q, xloc_d, yloc_q, yloc_d;
  logic [DIM-1:0]          xmin_q, xmin_d, xmax_q, xmax_d;
  logic [DIM-1:0]          ymin_q, ymin_d, ymax_q, ymax_d;
  logic [PID-1:0]          pid_q, pid_d;
  logic [2:0][2:0][DW-1:0] edges_q, edges_d;
  logic [DIM-1:0]          xb_out_q, xb_out_d, yb_out_q, yb_out_d;
  logic [2:0][2:0][DW-1:0] eblk_out_q, eblk_out_d;

  logic [CW-1:0]           bx, by;
  logic [DIM-1:0]          xb, yb;
  logic [DW-1:0]           dx, dy;
  logic [2:0][DW-1:0]      c_blk, a_pos, b_pos;
  logic [2:0][EW-1:0]      esum;
  logic                    edge_rej, bbox_rej, accept, last_blk;

  generate
    if (LD > 0) begin : g_multi
      assign bx = bidx_q[LD-1:0];
      assign by = bidx_q[2*LD-1:LD];
    end else begin : g_single
      assign bx = '0;
      assign by = '0;
    end
  endgenerate

  assign last_blk = (bidx_q == IW'(NBLK - 1));
  assign xb = xloc_q + (DIM'(bx) << BLOCK_LOGSIZE);
  assign yb = yloc_q + (DIM'(by) << BLOCK_LOGSIZE);
  assign dx = DW'(bx) << BLOCK_LOGSIZE;
  assign dy = DW'(by) << BLOCK_LOGSIZE;

  // Per-edge block c and the most-positive corner of the block for the reject test.
  always_comb begin
    c_blk    = '0;
    a_pos    = '0;
    b_pos    = '0;
    esum     = '0;
    edge_rej = 1'b0;
    for (int k = 0; k < 3; k++) begin
      c_blk[k] = edges_q[k][2] + edges_q[k][0] * dx + edges_q[k][1] * dy;
      a_pos[k] = edges_q[k][0][DW-1] ? '0 : edges_q[k][0];
      b_pos[k] = edges_q[k][1][DW-1] ? '0 : edges_q[k][1];
      esum[k]  = {{(EW-DW){c_blk[k][DW-1]}}, c_blk[k]}
               + EW'(a_pos[k]) * EW'(BS - 1)
               + EW'(b_pos[k]) * EW'(BS - 1);
      edge_rej = edge_rej | esum[k][EW-1];
    end
  end

  assign bbox_rej = (xb >= xmax_q)
                  | (({1'b0, xb} + DIM1'(BS)) <= {1'b0, xmin_q})
                  | (yb >= ymax_q)
                  | (({1'b0, yb} + DIM1'(BS)) <= {1'b0, ymin_q});
  assign accept   = !edge_rej && !bbox_rej;

  always_comb begin
    state_d    = state_q;
    bidx_d     = bidx_q;
    xloc_d     = xloc_q;
    yloc_d     = yloc_q;
    xmin_d     = xmin_q;
    xmax_d     = xmax_q;
    ymin_d     = ymin_q;
    ymax_d     = ymax_q;
    pid_d      = pid_q;
    edges_d    = edges_q;
    xb_out_d   = xb_out_q;
    yb_out_d   = yb_out_q;
    eblk_out_d = eblk_out_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          xloc_d  = xloc_in;
          yloc_d  = yloc_in;
          xmin_d  = xmin_in;
          xmax_d  = xmax_in;
          ymin_d  = ymin_in;
          ymax_d  = ymax_in;
          pid_d   = pid_in;
          edges_d = edges_in;
          bidx_d  = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (accept) begin
          xb_out_d = xb;
          yb_out_d = yb;
          for (int k = 0; k < 3; k++) begin
            eblk_out_d[k][0] = edges_q[k][0];
            eblk_out_d[k][1] = edges_q[k][1];
            eblk_out_d[k][2] = c_blk[k];
          end
          state_d = EMIT;
        end else if (last_blk) begin
          state_d = IDLE;
        end else begin
          bidx_d = bidx_q + 1'b1;
        end
      end
      EMIT: begin
        if (ready_out) begin
          if (last_blk) begin
            state_d = IDLE;
          end else begin
            bidx_d  = bidx_q + 1'b1;
            state_d = SCAN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bidx_q  <= '0;
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
    end
  end

  // Payload registers carry no reset; they are only observed while valid_out is high.
  always_ff @(posedge clk) begin
    xloc_q     <= xloc_d;
    yloc_q     <= yloc_d;
    xmin_q     <= xmin_d;
    xmax_q     <= xmax_d;
    ymin_q     <= ymin_d;
    ymax_q     <= ymax_d;
    pid_q      <= pid_d;
    edges_q    <= edges_d;
    xb_out_q   <= xb_out_d;
    yb_out_q   <= yb_out_d;
    eblk_out_q <= eblk_out_d;
  end

  assign ready_in  = (state_q == IDLE);
  assign valid_out = (state_q == EMIT);
  assign busy_out  = (state_q != IDLE);
  assign xloc_out  = xb_out_q;
  assign yloc_out  = yb_out_q;
  assign edges_out = eblk_out_q;
  assign xmin_out  = xmin_q;
  assign xmax_out  = xmax_q;
  assign ymin_out  = ymin_q;
  assign ymax_out  = ymax_q;
  assign pid_out   = pid_q;

endmodule

// File: tb/tb_raster_block_gen.sv
// Self-checking bench for raster_block_gen: directed table, stall/reset sequences, random tiles vs a reference model.
`timescale 1ns/1ps
`ifndef VX_RASTER_DIM_BITS
`define VX_RASTER_DIM_BITS 16
`endif
`ifndef VX_RASTER_PID_BITS
`define VX_RASTER_PID_BITS 16
`endif
`ifndef RASTER_DATA_BITS
`define RASTER_DATA_BITS 32
`endif

module tb_raster_block_gen;

  localparam int TL  = 6;
  localparam int BL  = 5;
  localparam int DIM = `VX_RASTER_DIM_BITS;
  localparam int PID = `VX_RASTER_PID_BITS;
  localparam int DW  = `RASTER_DATA_BITS;
  localparam int BS  = 1 << BL;
  localparam int NB  = 1 << (TL - BL);

  typedef struct packed {
    logic [DIM-1:0]          xloc, yloc, xmin, xmax, ymin, ymax;
    logic [PID-1:0]          pid;
    logic [2:0][2:0][DW-1:0] e;   // e[k] = {c, b, a} with a at index 0
  } tile_t;

  typedef struct packed {
    logic [DIM-1:0]     x, y;
    logic [2:0][DW-1:0] c;
  } blk_t;

  typedef struct packed {
    tile_t                t;
    int                   n;
    logic [3:0][DIM-1:0]  ex, ey;
    logic [3:0][DW-1:0]   ec0;
    int                   first;
    int                   idle;
  } vec_t;

  logic clk = 1'b0;
  logic reset, valid_in, ready_in, valid_out, ready_out, busy_out;
  logic [DIM-1:0] xloc_in, yloc_in, xmin_in, xmax_in, ymin_in, ymax_in;
  logic [DIM-1:0] xloc_out, yloc_out, xmin_out, xmax_out, ymin_out, ymax_out;
  logic [PID-1:0] pid_in, pid_out;
  logic [2:0][2:0][DW-1:0] edges_in, edges_out;

  int errors = 0;
  int checks = 0;
  blk_t got_q[$];
  blk_t exp_q[$];
  vec_t vt[5];

  always #5 clk = ~clk;

  raster_block_gen #(.TILE_LOGSIZE(TL), .BLOCK_LOGSIZE(BL)) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .ready_in(ready_in),
    .xloc_in(xloc_in), .yloc_in(yloc_in),
    .xmin_in(xmin_in), .xmax_in(xmax_in), .ymin_in(ymin_in), .ymax_in(ymax_in),
    .pid_in(pid_in), .edges_in(edges_in),
    .valid_out(valid_out), .xloc_out(xloc_out), .yloc_out(yloc_out),
    .xmin_out(xmin_out), .xmax_out(xmax_out), .ymin_out(ymin_out), .ymax_out(ymax_out),
    .pid_out(pid_out), .edges_out(edges_out), .ready_out(ready_out),
    .busy_out(busy_out)
  );

  task automatic check(input string nm, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic fail_timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got=timeout expected=event", nm);
  endtask

  function automatic tile_t mk_tile(input int xl, input int yl, input int xmn, input int xmx,
                                    input int ymn, input int ymx, input int pid,
                                    input int a0, input int b0, input int c0);
    tile_t t;
    t.xloc = DIM'(xl); t.yloc = DIM'(yl);
    t.xmin = DIM'(xmn); t.xmax = DIM'(xmx);
    t.ymin = DIM'(ymn); t.ymax = DIM'(ymx);
    t.pid  = PID'(pid);
    for (int k = 0; k < 3; k++) begin
      t.e[k][0] = '0; t.e[k][1] = '0; t.e[k][2] = DW'(1);
    end
    t.e[0][0] = DW'(a0); t.e[0][1] = DW'(b0); t.e[0][2] = DW'(c0);
    return t;
  endfunction

  task automatic add_exp(input int i, input int x, input int y, input int c0);
    vt[i].ex[vt[i].n]  = DIM'(x);
    vt[i].ey[vt[i].n]  = DIM'(y);
    vt[i].ec0[vt[i].n] = DW'(c0);
    vt[i].n++;
  endtask

  // Reference: walk the block grid and apply the origin, edge and bbox rules directly.
  function automatic void model(input tile_t t);
    exp_q.delete();
    for (int by = 0; by < NB; by++) begin
      for (int bx = 0; bx < NB; bx++) begin
        longint xb, yb, a, b, c, cs, s;
        logic [DW-1:0] cw;
        blk_t blk;
        bit rej;
        xb = (longint'(t.xloc) + longint'(bx * BS)) % (longint'(1) << DIM);
        yb = (longint'(t.yloc) + longint'(by * BS)) % (longint'(1) << DIM);
        rej = (xb >= longint'(t.xmax)) || (xb + BS <= longint'(t.xmin)) ||
              (yb >= longint'(t.ymax)) || (yb + BS <= longint'(t.ymin));
        for (int k = 0; k < 3; k++) begin
          a  = longint'($signed(t.e[k][0]));
          b  = longint'($signed(t.e[k][1]));
          c  = longint'($signed(t.e[k][2]));
          cw = DW'(c + a * bx * BS + b * by * BS);
          cs = longint'($signed(cw));
          s  = cs + ((a > 0) ? a : 0) * (BS - 1) + ((b > 0) ? b : 0) * (BS - 1);
          if (s < 0) rej = 1'b1;
          blk.c[k] = cw;
        end
        blk.x = DIM'(xb);
        blk.y = DIM'(yb);
        if (!rej) exp_q.push_back(blk);
      end
    end
  endfunction

  function automatic void exp_from_table(input int i);
    blk_t blk;
    exp_q.delete();
    for (int j = 0; j < vt[i].n; j++) begin
      blk.x = vt[i].ex[j];
      blk.y = vt[i].ey[j];
      blk.c[0] = vt[i].ec0[j];
      blk.c[1] = DW'(1);
      blk.c[2] = DW'(1);
      exp_q.push_back(blk);
    end
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    int r;
    t.xloc = ($urandom_range(0, 3) == 0) ? DIM'(32'hFFFF_FFC0 + $urandom_range(0, 63)) : DIM'($urandom);
    t.yloc = DIM'($urandom);
    r = int'($urandom_range(0, 80));
    t.xmin = DIM'(int'(t.xloc) + r - 10);
    t.xmax = DIM'(int'(t.xmin) + int'($urandom_range(1, 80)));
    r = int'($urandom_range(0, 80));
    t.ymin = DIM'(int'(t.yloc) + r - 10);
    t.ymax = DIM'(int'(t.ymin) + int'($urandom_range(1, 80)));
    if ($urandom_range(0, 3) == 0) begin
      t.xmin = '0; t.xmax = '1; t.ymin = '0; t.ymax = '1;
    end
    t.pid = PID'($urandom);
    for (int k = 0; k < 3; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        t.e[k][0] = DW'($urandom); t.e[k][1] = DW'($urandom); t.e[k][2] = DW'($urandom);
      end else begin
        t.e[k][0] = DW'(int'($urandom_range(0, 8)) - 4);
        t.e[k][1] = DW'(int'($urandom_range(0, 8)) - 4);
        t.e[k][2] = DW'(int'($urandom_range(0, 600)) - 200);
      end
    end
    return t;
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that accepted the tile.
  task automatic fire_tile(input tile_t t, output bit ok);
    int w;
    xloc_in = t.xloc; yloc_in = t.yloc;
    xmin_in = t.xmin; xmax_in = t.xmax; ymin_in = t.ymin; ymax_in = t.ymax;
    pid_in = t.pid; edges_in = t.e;
    valid_in = 1'b1;
    w = 0;
    while (!ready_in && w < 50) begin
      @(posedge clk); #1; w++;
    end
    ok = ready_in;
    if (!ok) fail_timeout("in_rdy_timeout");
    else begin
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
  endtask

  // mode 0: ready_out always high; 1: random ready_out; 2: first block stalled 5 cycles.
  task automatic run_tile(input tile_t t, input int mode, output int idle_at, output int first_at);
    bit ok, pv, pr;
    logic [DIM-1:0] px, py;
    logic [2:0][2:0][DW-1:0] pe;
    int stall;
    blk_t g;
    got_q.delete();
    idle_at = -1; first_at = -1; pv = 1'b0; pr = 1'b0; stall = 0;
    px = '0; py = '0; pe = '0;
    fire_tile(t, ok);
    if (ok) begin
      for (int n = 1; n <= 200; n++) begin
        if (pv && !pr) begin
          check("hold_vld", valid_out, 1'b1);
          check("hold_dat", {xloc_out, yloc_out, edges_out}, {px, py, pe});
          check("hold_rdy_in", ready_in, 1'b0);
        end
        check("busy", busy_out, !ready_in);
        if (ready_in) begin
          idle_at = n;
          break;
        end
        case (mode)
          1:       ready_out = ($urandom_range(0, 3) != 0);
          2:       ready_out = (stall >= 5);
          default: ready_out = 1'b1;
        endcase
        if (valid_out) begin
          if (first_at < 0) first_at = n;
          if (!ready_out) stall++;
          else begin
            g.x = xloc_out; g.y = yloc_out;
            for (int k = 0; k < 3; k++) g.c[k] = edges_out[k][2];
            got_q.push_back(g);
            check("fwd", {xmin_out, xmax_out, ymin_out, ymax_out, pid_out,
                          edges_out[0][1:0], edges_out[1][1:0], edges_out[2][1:0]},
                         {t.xmin, t.xmax, t.ymin, t.ymax, t.pid,
                          t.e[0][1:0], t.e[1][1:0], t.e[2][1:0]});
          end
        end
        pv = valid_out; pr = ready_out;
        px = xloc_out; py = yloc_out; pe = edges_out;
        @(posedge clk); #1;
      end
      if (idle_at < 0) fail_timeout("done_timeout");
    end
    ready_out = 1'b0;
  endtask

  task automatic compare_blocks();
    check("nblk", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check("blk_xy", {got_q[i].x, got_q[i].y}, {exp_q[i].x, exp_q[i].y});
      check("blk_c", got_q[i].c, exp_q[i].c);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=no_finish expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_at, first_at, seen, w, nv;
    bit ok;

    for (int i = 0; i < 5; i++) vt[i].n = 0;
    vt[0].t = mk_tile(0, 0, 0, 64, 0, 64, 'h5A, 0, 0, 1);
    add_exp(0, 0, 0, 1); add_exp(0, 32, 0, 1); add_exp(0, 0, 32, 1); add_exp(0, 32, 32, 1);
    vt[0].first = 2; vt[0].idle = 9;
    vt[1].t = mk_tile(0, 0, 0, 64, 0, 64, 'h21, 1, 0, -40);
    add_exp(1, 32, 0, -8); add_exp(1, 32, 32, -8);
    vt[1].first = 3; vt[1].idle = 7;
    vt[2].t = mk_tile(0, 0, 0, 32, 0, 64, 'h33, 0, 0, 1);
    add_exp(2, 0, 0, 1); add_exp(2, 0, 32, 1);
    vt[2].first = 2; vt[2].idle = 7;
    vt[3].t = mk_tile(0, 0, 0, 64, 0, 64, 'h44, 0, 0, -1);
    vt[3].first = -1; vt[3].idle = 5;
    vt[4].t = mk_tile('hFFE0, 'h10, 0, 'hFFFF, 0, 'h100, 'h77, 2, 3, 5);
    add_exp(4, 'hFFE0, 'h10, 5); add_exp(4, 0, 'h10, 69);
    add_exp(4, 'hFFE0, 'h30, 101); add_exp(4, 0, 'h30, 165);
    vt[4].first = 2; vt[4].idle = 9;

    reset = 1'b1; valid_in = 1'b0; ready_out = 1'b0;
    xloc_in = '0; yloc_in = '0; xmin_in = '0; xmax_in = '0; ymin_in = '0; ymax_in = '0;
    pid_in = '0; edges_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", valid_out, 1'b0);
    check("rst_busy", busy_out, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_rdy_in", ready_in, 1'b1);

    for (int i = 0; i < 5; i++) begin
      run_tile(vt[i].t, 0, idle_at, first_at);
      exp_from_table(i);
      compare_blocks();
      check("first_vld_cycle", first_at, vt[i].first);
      check("idle_cycle", idle_at, vt[i].idle);
    end

    run_tile(vt[0].t, 2, idle_at, first_at);
    exp_from_table(0);
    compare_blocks();
    check("stall_idle_cycle", idle_at, 14);

    fire_tile(vt[0].t, ok);
    ready_out = 1'b1; seen = 0; w = 0;
    while (seen < 2 && w < 40) begin
      if (valid_out) seen++;
      if (seen < 2) begin
        @(posedge clk); #1; w++;
      end
    end
    if (seen < 2) fail_timeout("emit1_timeout");
    ready_out = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_vld", valid_out, 1'b0);
    check("midrst_busy", busy_out, 1'b0);
    reset = 1'b0;
    ready_out = 1'b1;
    @(posedge clk); #1;
    check("midrst_rdy_in", ready_in, 1'b1);
    nv = 0;
    for (int n = 0; n < 12; n++) begin
      if (valid_out) nv++;
      @(posedge clk); #1;
    end
    check("midrst_drop", nv, 0);
    ready_out = 1'b0;
    run_tile(vt[0].t, 0, idle_at, first_at);
    exp_from_table(0);
    compare_blocks();

    for (int r = 0; r < 60; r++) begin
      tile_t t;
      t = rand_tile();
      model(t);
      run_tile(t, 1, idle_at, first_at);
      compare_blocks();
      if (first_at >= 0) check("rand_lat_min", first_at >= 2, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
